esp_led_writer: RTL and testbench

Write-direction companion to the ESP32-to-FPGA switch readout path: the ESP32 pushes commands over its GPIO nibble bus plus a strobe line, and this block decodes them into a registered 16-bit LED/output register. Each transaction is two strobed nibbles: an index, then a command. The block acknowledges via a level handshake and flags protocol errors. It sits directly behind the ESP32 GPIO pins, alongside the switch-select multiplexer, in the same clock domain as the rest of the fabric.

---
 rtl/esp_led_writer.sv | 97 +++++++++
 tb/tb_esp_led_writer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/esp_led_writer.sv
// ESP32 nibble-bus command decoder driving a registered 16-bit LED register.
// Each transaction is two strobed nibbles: an index, then a command.
module esp_led_writer #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:3]  ESP,
    input  logic        STB,
    output logic [0:15] LED,
    output logic        ACK,
    output logic        ERR
);

    // state   | meaning
    // IDLE    | waiting for the index nibble, ACK low
    // GOT_IDX | index held, waiting for the command nibble, ACK high
    typedef enum logic {
        IDLE    = 1'b0,
        GOT_IDX = 1'b1
    } state_t;

    localparam int             CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  TC = CW'(TIMEOUT - 1);

    state_t                          state;
    logic [SYNC_STAGES-1:0]          stb_sync;
    logic [SYNC_STAGES-1:0][3:0]     esp_sync;
    logic                            stb_prev;
    logic                            stb_edge;
    logic [3:0]                      nib;
    logic [3:0]                      idx;
    logic [CW-1:0]                   cnt;
    logic [15:0]                     led_q;

    assign stb_edge = stb_sync[SYNC_STAGES-1] & ~stb_prev;
    assign nib      = esp_sync[SYNC_STAGES-1];
    // Numeric bit weight 2^i of LED is addressed by index i.
    assign LED      = led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_sync <= '0;
            esp_sync <= '0;
            stb_prev <= 1'b0;
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            led_q    <= '0;
            ACK      <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], STB};
            esp_sync <= {esp_sync[SYNC_STAGES-2:0], ESP};
            stb_prev <= stb_sync[SYNC_STAGES-1];

            case (state)
                IDLE: begin
                    if (stb_edge) begin
                        idx   <= nib;
                        cnt   <= '0;
                        ACK   <= 1'b1;
                        state <= GOT_IDX;
                    end
                end
                GOT_IDX: begin
                    cnt <= cnt + 1'b1;
                    // A command edge wins over the terminal count in the same cycle.
                    if (stb_edge) begin
                        case (nib)
                            4'd0:    led_q[idx] <= 1'b0;
                            4'd1:    led_q[idx] <= 1'b1;
                            4'd2:    led_q[idx] <= ~led_q[idx];
                            4'd3:    led_q      <= '0;
                            4'd4:    led_q      <= '1;
                            4'd5:    led_q      <= ~led_q;
                            4'd15:   ERR        <= 1'b0;
                            default: ERR        <= 1'b1;
                        endcase
                        ACK   <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == TC) begin
                        ERR   <= 1'b1;
                        ACK   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ACK   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_esp_led_writer.sv
// Directed and randomized transactions for esp_led_writer, checked against
// a transaction-level model of the LED register and error flag.
module tb_esp_led_writer;

    logic        clk;
    logic        rst;
    logic [0:3]  ESP;
    logic        STB;
    logic [0:15] LED;
    logic        ACK;
    logic        ERR;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_led;
    logic        m_err;

    esp_led_writer #(.SYNC_STAGES(2), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .ESP (ESP),
        .STB (STB),
        .LED (LED),
        .ACK (ACK),
        .ERR (ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level effect of one command on the model state.
    task automatic model_cmd(input int i, input int c);
        logic [15:0] bitm;
        bitm = 16'(1) << i;
        if (c == 0)       m_led = m_led & ~bitm;
        else if (c == 1)  m_led = m_led | bitm;
        else if (c == 2)  m_led = m_led ^ bitm;
        else if (c == 3)  m_led = 16'h0000;
        else if (c == 4)  m_led = 16'hFFFF;
        else if (c == 5)  m_led = ~m_led;
        else if (c == 15) m_err = 1'b0;
        else              m_err = 1'b1;
    endtask

    task automatic check_state(input string tag, input logic exp_ack);
        chk({tag, "_led"}, 32'(LED), 32'(m_led));
        chk({tag, "_ack"}, 32'(ACK), 32'(exp_ack));
        chk({tag, "_err"}, 32'(ERR), 32'(m_err));
    endtask

    // Index nibble: STB first sampled high at the edge after it is driven,
    // ACK must rise exactly on the third edge.
    task automatic send_idx(input logic [3:0] i);
        STB = 1'b0;
        ESP = i;
        repeat (3) step();
        STB = 1'b1;
        repeat (2) step();
        chk("idx_ack_early", 32'(ACK), 32'd0);
        step();
        check_state("idx", 1'b1);
    endtask

    task automatic send_cmd(input logic [3:0] i, input logic [3:0] c);
        STB = 1'b0;
        ESP = c;
        repeat (3) step();
        STB = 1'b1;
        repeat (2) step();
        chk("cmd_ack_early", 32'(ACK), 32'd1);
        chk("cmd_led_early", 32'(LED), 32'(m_led));
        step();
        model_cmd(int'(i), int'(c));
        check_state("cmd", 1'b0);
    endtask

    task automatic txn(input logic [3:0] i, input logic [3:0] c);
        send_idx(i);
        send_cmd(i, c);
    endtask

    initial begin
        m_led = '0;
        m_err = 1'b0;
        rst   = 1'b1;
        STB   = 1'b0;
        ESP   = 4'h0;
        #1;
        repeat (3) step();
        check_state("reset", 1'b0);
        rst = 1'b0;
        repeat (2) step();
        check_state("post_reset", 1'b0);

        txn(4'd5, 4'd1);
        chk("basic_0020", 32'(LED), 32'h0020);

        txn(4'd0, 4'd3);
        txn(4'd0, 4'd1);
        txn(4'd15, 4'd1);
        txn(4'd15, 4'd2);
        chk("bitops_0001", 32'(LED), 32'h0001);

        txn(4'd11, 4'd4);
        chk("bulk_ffff", 32'(LED), 32'hFFFF);
        txn(4'd3, 4'd0);
        chk("bulk_fff7", 32'(LED), 32'hFFF7);
        txn(4'd9, 4'd5);
        chk("bulk_0008", 32'(LED), 32'h0008);

        txn(4'd2, 4'd9);
        chk("invalid_err", 32'(ERR), 32'd1);
        txn(4'd7, 4'd15);
        chk("clear_err", 32'(ERR), 32'd0);

        // Timeout: ACK rose at edge E; it must fall with ERR at edge E+8.
        send_idx(4'd4);
        STB = 1'b0;
        repeat (7) step();
        chk("to_ack_hold", 32'(ACK), 32'd1);
        step();
        m_err = 1'b1;
        check_state("timeout", 1'b0);

        txn(4'd0, 4'd15);

        // Tie: command edge detected in the terminal-count cycle (edge E+8).
        send_idx(4'd6);
        STB = 1'b0;
        ESP = 4'd1;
        repeat (5) step();
        STB = 1'b1;
        repeat (2) step();
        chk("tie_ack_hold", 32'(ACK), 32'd1);
        step();
        model_cmd(6, 1);
        check_state("tie", 1'b0);

        for (int n = 0; n < 24; n++) begin
            logic [3:0] ri, rc;
            ri = 4'($urandom_range(0, 15));
            rc = 4'($urandom_range(0, 15));
            txn(ri, rc);
        end

        // Reset mid-transaction.
        txn(4'd0, 4'd3);
        for (int b = 4; b < 8; b++) txn(4'(b), 4'd1);
        txn(4'd0, 4'd15);
        chk("pre_rst_00f0", 32'(LED), 32'h00F0);
        send_idx(4'd9);
        rst = 1'b1;
        STB = 1'b0;
        #1;
        m_led = '0;
        m_err = 1'b0;
        check_state("mid_rst", 1'b0);
        step();
        rst = 1'b0;
        repeat (2) step();
        txn(4'd1, 4'd1);
        chk("after_rst_0002", 32'(LED), 32'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
